// File: rtl/port_egress_queue.sv
// Egress queue for one switch port: a packet FIFO feeding a paced output
// stage that emits one valid_out pulse per packet, with optional forced idle
// cycles between pulses and saturating drop/misroute counters.
// Optional feature: define SWITCH_EGRESS_TARGET_CHECK_EN to discard packets
// whose target is not PORT_ID (counted in misroute_count).

package packet_pkg;
  localparam int ADDR_WIDTH = 4;
  localparam int DATA_WIDTH = 16;
endpackage

module port_egress_queue
  import packet_pkg::*;
#(
  parameter int                    DEPTH   = 8,
  parameter int                    GAP     = 0,
  parameter logic [ADDR_WIDTH-1:0] PORT_ID = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enq_valid,
  input  logic [ADDR_WIDTH-1:0]      enq_source,
  input  logic [ADDR_WIDTH-1:0]      enq_target,
  input  logic [DATA_WIDTH-1:0]      enq_data,
  output logic                       enq_ready,
  input  logic                       tx_pause,
  output logic                       valid_out,
  output logic [ADDR_WIDTH-1:0]      source_out,
  output logic [ADDR_WIDTH-1:0]      target_out,
  output logic [DATA_WIDTH-1:0]      data_out,
  output logic [$clog2(DEPTH):0]     level,
  output logic [15:0]                drop_count,
  output logic [7:0]                 misroute_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP} state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] source;
    logic [ADDR_WIDTH-1:0] target;
    logic [DATA_WIDTH-1:0] data;
  } pkt_t;

  pkt_t            mem [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [3:0]      gap_cnt;
  state_t          state, next_state;
  logic            pop, gap_load;
  logic            full, has_pkt, target_ok, push, drop;

  assign full      = (level == LW'(DEPTH));
  assign has_pkt   = (level != '0);
  assign enq_ready = ~full;

`ifdef SWITCH_EGRESS_TARGET_CHECK_EN
  assign target_ok = (enq_target == PORT_ID);
`else
  assign target_ok = 1'b1;
  logic unused_port_id;
  assign unused_port_id = ^PORT_ID;
`endif

  // Full check wins over the target check: a packet offered while full is a drop only.
  assign push = enq_valid & ~full & target_ok;
  assign drop = enq_valid & full;

  // Output FSM state register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // Next-state, pop and gap-load decisions.
  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    gap_load   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (has_pkt && !tx_pause) begin
          pop        = 1'b1;
          next_state = ST_SEND;
        end
      end
      ST_SEND: begin
        if (GAP > 0) begin
          gap_load   = 1'b1;
          next_state = ST_GAP;
        end else if (has_pkt && !tx_pause) begin
          pop = 1'b1;
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_GAP: begin
        // Leave when this decrement brings the counter to 1 (or it already is).
        if (gap_cnt <= 4'd2) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Gap counter: loaded on leaving SEND, counts down while in GAP.
  always_ff @(posedge clk) begin
    if (rst)                              gap_cnt <= '0;
    else if (gap_load)                    gap_cnt <= 4'(GAP);
    else if (state == ST_GAP && gap_cnt != '0) gap_cnt <= gap_cnt - 4'd1;
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push);
      rd_ptr <= rd_ptr + PW'(pop);
      level  <= level + LW'(push) - LW'(pop);
    end
  end

  // Packet storage write port.
  // NOTE: storage is not reset; level and pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{source: enq_source, target: enq_target, data: enq_data};
  end

  // Output registers: pulse on pop, fields hold between pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_out  <= 1'b0;
      source_out <= '0;
      target_out <= '0;
      data_out   <= '0;
    end else begin
      valid_out <= pop;
      if (pop) begin
        source_out <= mem[rd_ptr].source;
        target_out <= mem[rd_ptr].target;
        data_out   <= mem[rd_ptr].data;
      end
    end
  end

  // Saturating drop counter.
  always_ff @(posedge clk) begin
    if (rst)                          drop_count <= '0;
    else if (drop && drop_count != '1) drop_count <= drop_count + 16'd1;
  end

`ifdef SWITCH_EGRESS_TARGET_CHECK_EN
  // Saturating misroute counter for packets rejected by the target check.
  always_ff @(posedge clk) begin
    if (rst) misroute_count <= '0;
    else if (enq_valid && !full && !target_ok && misroute_count != '1)
      misroute_count <= misroute_count + 8'd1;
  end
`else
  assign misroute_count = '0;
`endif

endmodule

// File: tb/tb_port_egress_queue.sv
// Self-checking bench for port_egress_queue: directed scenarios plus a random
// phase, compared against a queue-based reference model. A second instance
// with GAP=2 checks output pacing.

module tb_port_egress_queue;
  import packet_pkg::*;

  localparam int                    DEPTH   = 8;
  localparam logic [ADDR_WIDTH-1:0] PORT_ID = 4'd2;
  localparam int                    LW      = $clog2(DEPTH) + 1;

  logic                  clk = 1'b0;
  logic                  rst, enq_valid, tx_pause;
  logic [ADDR_WIDTH-1:0] enq_source, enq_target;
  logic [DATA_WIDTH-1:0] enq_data;

  logic                  a_ready, a_valid, b_ready, b_valid;
  logic [ADDR_WIDTH-1:0] a_src, a_tgt, b_src, b_tgt;
  logic [DATA_WIDTH-1:0] a_data, b_data;
  logic [LW-1:0]         a_level, b_level;
  logic [15:0]           a_drop, b_drop;
  logic [7:0]            a_mis, b_mis;

  port_egress_queue #(.DEPTH(DEPTH), .GAP(0), .PORT_ID(PORT_ID)) dut_a (
    .clk(clk), .rst(rst), .enq_valid(enq_valid), .enq_source(enq_source),
    .enq_target(enq_target), .enq_data(enq_data), .enq_ready(a_ready),
    .tx_pause(tx_pause), .valid_out(a_valid), .source_out(a_src),
    .target_out(a_tgt), .data_out(a_data), .level(a_level),
    .drop_count(a_drop), .misroute_count(a_mis));

  port_egress_queue #(.DEPTH(DEPTH), .GAP(2), .PORT_ID(PORT_ID)) dut_b (
    .clk(clk), .rst(rst), .enq_valid(enq_valid), .enq_source(enq_source),
    .enq_target(enq_target), .enq_data(enq_data), .enq_ready(b_ready),
    .tx_pause(tx_pause), .valid_out(b_valid), .source_out(b_src),
    .target_out(b_tgt), .data_out(b_data), .level(b_level),
    .drop_count(b_drop), .misroute_count(b_mis));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] src;
    logic [ADDR_WIDTH-1:0] tgt;
    logic [DATA_WIDTH-1:0] data;
  } pkt_t;

  // Reference model state (GAP=0 instance): packets waiting, counters, last output.
  pkt_t q[$];
  int   m_drop, m_mis;
  logic m_valid;
  pkt_t m_out;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [ADDR_WIDTH-1:0] tgt, input logic pause);
    enq_valid  = v;
    enq_source = ADDR_WIDTH'($urandom);
    enq_target = tgt;
    enq_data   = DATA_WIDTH'($urandom);
    tx_pause   = pause;
  endtask

  // Advance the model by one edge from the current inputs, clock the DUT, compare.
  task automatic step();
    bit   do_pop, accept;
    pkt_t p;
    if (rst) begin
      q.delete();
      m_drop  = 0;
      m_mis   = 0;
      m_valid = 1'b0;
      m_out   = '0;
    end else begin
      do_pop = (q.size() > 0) && !tx_pause;
      accept = enq_valid && (q.size() != DEPTH);
      if (enq_valid && q.size() == DEPTH && m_drop < 16'hFFFF) m_drop++;
      m_valid = do_pop;
      if (do_pop) m_out = q.pop_front();
      if (accept) begin
        p = '{src: enq_source, tgt: enq_target, data: enq_data};
`ifdef SWITCH_EGRESS_TARGET_CHECK_EN
        if (enq_target != PORT_ID) begin
          if (m_mis < 8'hFF) m_mis++;
        end else q.push_back(p);
`else
        q.push_back(p);
`endif
      end
    end
    @(posedge clk);
    #1;
    chk("valid_out", 32'(a_valid), 32'(m_valid));
    chk("level", 32'(a_level), 32'(q.size()));
    chk("enq_ready", 32'(a_ready), 32'(q.size() != DEPTH));
    chk("drop_count", 32'(a_drop), 32'(m_drop));
    chk("misroute_count", 32'(a_mis), 32'(m_mis));
    chk("out_fields", 32'({a_src, a_tgt, a_data}), 32'(m_out));
  endtask

  int   pulses;
  pkt_t first_b;

  initial begin
    rst = 1'b1;
    drive(1'b0, PORT_ID, 1'b0);
    step();
    step();
    rst = 1'b0;
    step();
    chk("reset_b_level", 32'(b_level), 32'd0);
    chk("reset_b_valid", 32'(b_valid), 32'd0);

    // Three back-to-back packets: three consecutive pulses, in order.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, PORT_ID, 1'b0);
      step();
    end
    drive(1'b0, PORT_ID, 1'b0);
    for (int i = 0; i < 4; i++) step();

    // Paused fill past capacity: two drops, then drain all eight.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, PORT_ID, 1'b1);
      step();
    end
    chk("fill_level", 32'(a_level), 32'd8);
    chk("fill_ready", 32'(a_ready), 32'd0);
    chk("fill_drop", 32'(a_drop), 32'd2);
    drive(1'b0, PORT_ID, 1'b0);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (a_valid) pulses++;
    end
    chk("drain_pulses", 32'(pulses), 32'd8);
    chk("drain_level", 32'(a_level), 32'd0);

    // Full queue, pop and offer on the same edge: offer is dropped, level 7.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, PORT_ID, 1'b1);
      step();
    end
    drive(1'b1, PORT_ID, 1'b0);
    step();
    chk("full_pop_level", 32'(a_level), 32'd7);
    chk("full_pop_drop", 32'(a_drop), 32'd3);
    drive(1'b0, PORT_ID, 1'b0);
    for (int i = 0; i < 9; i++) step();

    // Random traffic with bursty pause to visit full and empty.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(9) < 6,
            $urandom_range(1) ? PORT_ID : ADDR_WIDTH'($urandom_range(15)),
            (i < 200) ? ($urandom_range(1) == 0) : ($urandom_range(4) == 0));
      step();
    end

    // Reset while holding five packets and presenting one.
    drive(1'b0, PORT_ID, 1'b0);
    for (int i = 0; i < 10; i++) step();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, PORT_ID, 1'b1);
      step();
    end
    drive(1'b1, PORT_ID, 1'b0);
    step();
    chk("pre_rst_valid", 32'(a_valid), 32'd1);
    chk("pre_rst_level", 32'(a_level), 32'd5);
    rst = 1'b1;
    drive(1'b0, PORT_ID, 1'b0);
    step();
    chk("rst_valid", 32'(a_valid), 32'd0);
    chk("rst_level", 32'(a_level), 32'd0);
    chk("rst_drop", 32'(a_drop), 32'd0);
    chk("rst_ready", 32'(a_ready), 32'd1);
    rst = 1'b0;
    step();
    chk("post_rst_valid", 32'(a_valid), 32'd0);
    chk("post_rst_ready", 32'(a_ready), 32'd1);

    // GAP=2 instance: two packets give pulses separated by two low cycles.
    drive(1'b1, PORT_ID, 1'b0);
    first_b = '{src: enq_source, tgt: enq_target, data: enq_data};
    step();
    chk("gap_s1", 32'(b_valid), 32'd0);
    drive(1'b1, PORT_ID, 1'b0);
    step();
    chk("gap_s2", 32'(b_valid), 32'd1);
    chk("gap_first_data", 32'({b_src, b_tgt, b_data}), 32'(first_b));
    drive(1'b0, PORT_ID, 1'b0);
    step();
    chk("gap_s3", 32'(b_valid), 32'd0);
    step();
    chk("gap_s4", 32'(b_valid), 32'd0);
    step();
    chk("gap_s5", 32'(b_valid), 32'd1);
    step();
    chk("gap_s6", 32'(b_valid), 32'd0);
    chk("gap_hold", 32'(b_level), 32'd0);

    // Targets 2,3,2 toward PORT_ID 2.
    rst = 1'b1;
    step();
    rst = 1'b0;
    pulses = 0;
    drive(1'b1, 4'd2, 1'b0); step(); if (a_valid) pulses++;
    drive(1'b1, 4'd3, 1'b0); step(); if (a_valid) pulses++;
    drive(1'b1, 4'd2, 1'b0); step(); if (a_valid) pulses++;
    drive(1'b0, PORT_ID, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step();
      if (a_valid) pulses++;
    end
`ifdef SWITCH_EGRESS_TARGET_CHECK_EN
    chk("route_pulses", 32'(pulses), 32'd2);
    chk("route_mis", 32'(a_mis), 32'd1);
`else
    chk("route_pulses", 32'(pulses), 32'd3);
    chk("route_mis", 32'(a_mis), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
